// File: rtl/signal_head_driver.sv
// Railway signal head driver: decodes three 2-bit head codes into lamps and supervises them.
// Optional lamp-proving input and fault cause are enabled by defining LAMP_PROVE_EN.
module signal_head_driver #(
  parameter int FLASH_HALF     = 1,
  parameter int MIN_YELLOW     = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] L1,
  input  logic [1:0] L2,
  input  logic [1:0] L3,
  input  logic       clr_fault,
`ifdef LAMP_PROVE_EN
  input  logic [8:0] lamp_ok,
`endif
  output logic [8:0] lamps,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       flash_phase,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FAULT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] C_FLASH  = 2'b00;
  localparam logic [1:0] C_GREEN  = 2'b01;
  localparam logic [1:0] C_YELLOW = 2'b10;
  localparam logic [1:0] C_RED    = 2'b11;

  localparam logic [1:0] F_NONE     = 2'b00;
  localparam logic [1:0] F_CONFLICT = 2'b01;
  localparam logic [1:0] F_SEQUENCE = 2'b10;
  localparam logic [1:0] F_LAMP     = 2'b11;

  localparam logic [7:0] FLASH_LAST   = 8'(FLASH_HALF - 1);
  localparam logic [3:0] MIN_Y4       = 4'(MIN_YELLOW);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);
  localparam logic [8:0] ALL_RED      = 9'b001001001;

  state_t          state_q, state_d;
  logic [7:0]      flash_cnt;
  logic            flash_wrap, flash_next;
  logic [2:0][1:0] cur;
  logic [2:0][1:0] prev_q;
  logic [2:0][3:0] dwell_q, dwell_d;
  logic [3:0]      rec_cnt_q, rec_cnt_d;
  logic            conflict, seq_err, lamp_err, all_red, run_hold;
  logic [1:0]      cause, code_d;
  logic [8:0]      lamps_d;

  assign cur       = {L3, L2, L1};
  assign dbg_state = state_q;

  function automatic logic is_go(input logic [1:0] c);
    return (c == C_GREEN) || (c == C_YELLOW);
  endfunction

  // Returns {G,Y,R} for one head in RUN.
  function automatic logic [2:0] head_lamps(input logic [1:0] c, input logic ph);
    case (c)
      C_GREEN:  return 3'b100;
      C_YELLOW: return 3'b010;
      C_RED:    return 3'b001;
      default:  return {1'b0, ph, 1'b0};
    endcase
  endfunction

  // Lamps are registered alongside flash_phase, so decode against the phase it is about to take.
  assign flash_wrap = (flash_cnt == FLASH_LAST);
  assign flash_next = flash_wrap ? ~flash_phase : flash_phase;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      flash_cnt   <= 8'd0;
      flash_phase <= 1'b0;
    end else begin
      flash_cnt   <= flash_wrap ? 8'd0 : flash_cnt + 8'd1;
      flash_phase <= flash_next;
    end
  end

  assign conflict = is_go(L1) && (is_go(L2) || is_go(L3));
  assign all_red  = (L1 == C_RED) && (L2 == C_RED) && (L3 == C_RED);

  always_comb begin
    seq_err = 1'b0;
    dwell_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (prev_q[i] == C_GREEN  && cur[i] == C_RED)    seq_err = 1'b1;
      if (prev_q[i] == C_RED    && cur[i] == C_YELLOW) seq_err = 1'b1;
      if (prev_q[i] == C_YELLOW && cur[i] == C_GREEN)  seq_err = 1'b1;
      if (prev_q[i] == C_YELLOW && cur[i] == C_RED && dwell_q[i] < MIN_Y4) seq_err = 1'b1;
      if (cur[i] == C_YELLOW)
        dwell_d[i] = (dwell_q[i] == 4'd15) ? 4'd15 : dwell_q[i] + 4'd1;
    end
  end

`ifdef LAMP_PROVE_EN
  // bad_q remembers lamps that were commanded on but not proven in the previous cycle.
  logic [8:0] bad_q, bad_now;
  assign bad_now  = lamps & ~lamp_ok;
  assign lamp_err = |(bad_now & bad_q);
`else
  assign lamp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cause     = F_NONE;
    code_d    = fault_code;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      S_RUN: begin
        if (conflict)      cause = F_CONFLICT;
        else if (seq_err)  cause = F_SEQUENCE;
        else if (lamp_err) cause = F_LAMP;
        if (cause != F_NONE) begin
          state_d = S_FAULT;
          code_d  = cause;
        end
      end
      S_FAULT: begin
        if (clr_fault && all_red) begin
          state_d   = S_RECOVER;
          rec_cnt_d = 4'd0;
        end
      end
      S_RECOVER: begin
        if (!all_red) begin
          state_d = S_FAULT;
        end else if (rec_cnt_q == RECOVER_LAST) begin
          state_d = S_RUN;
          code_d  = F_NONE;
        end else begin
          rec_cnt_d = rec_cnt_q + 4'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    lamps_d = '0;
    if (state_d == S_RUN)
      lamps_d = {head_lamps(L3, flash_next), head_lamps(L2, flash_next), head_lamps(L1, flash_next)};
    else if (flash_next)
      lamps_d = ALL_RED;
  end

  // History is only tracked while staying in RUN; any other path reloads it as if all heads were Red.
  assign run_hold = (state_q == S_RUN) && (state_d == S_RUN);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_RUN;
      rec_cnt_q  <= 4'd0;
      prev_q     <= {C_RED, C_RED, C_RED};
      dwell_q    <= '0;
      lamps      <= ALL_RED;
      fault      <= 1'b0;
      fault_code <= F_NONE;
    end else begin
      state_q    <= state_d;
      rec_cnt_q  <= rec_cnt_d;
      prev_q     <= run_hold ? cur : {C_RED, C_RED, C_RED};
      dwell_q    <= run_hold ? dwell_d : '0;
      lamps      <= lamps_d;
      fault      <= (state_d != S_RUN);
      fault_code <= code_d;
    end
  end

`ifdef LAMP_PROVE_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) bad_q <= '0;
    else        bad_q <= run_hold ? bad_now : 9'd0;
  end
`endif

endmodule
